ascon_perm_ctrl: RTL
====================

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 12, maximum round count of the permutation datapath; the datapath is built with the same value.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port req_valid  input  1  requester has a permutation job.
REQ-005 Port req_rounds  input  4  rounds requested for the job; legal range 1..NUM_ROUNDS.
REQ-006 Port req_ready  output  1  controller can accept a job.
REQ-007 Port load_val  output  1  one-cycle strobe loading the datapath state registers.
REQ-008 Port rounds_enable  output  1  datapath applies one round this cycle.
REQ-009 Port round_ctr  output  4  round index driven to the datapath.
REQ-010 Port out_valid  output  1  permutation result is stable in the datapath registers.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port err  output  1  one-cycle pulse flagging a rejected job; tied 0 unless REQ-030 applies.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, ROUND, DONE; all outputs are decoded from registered state and counter only, except req_ready.
REQ-015 req_ready SHALL be 1 only in IDLE; a job is accepted in the cycle where req_valid && req_ready, and req_rounds is latched that cycle.
REQ-016 On acceptance, IDLE -> LOAD; round_ctr is loaded with NUM_ROUNDS - req_rounds (4-bit unsigned, no wrap for legal values).
REQ-017 LOAD SHALL last one cycle with load_val=1, rounds_enable=0, then -> ROUND.
REQ-018 In ROUND, rounds_enable=1 and round_ctr increments by 1 per cycle; when round_ctr == NUM_ROUNDS-1 the state moves to DONE and round_ctr becomes NUM_ROUNDS.
REQ-019 ROUND SHALL therefore last exactly req_rounds cycles, issuing round indices NUM_ROUNDS-req_rounds .. NUM_ROUNDS-1 in order.
REQ-020 In DONE, out_valid=1, round_ctr=NUM_ROUNDS, load_val=0, rounds_enable=0; DONE holds while out_ready=0.
REQ-021 DONE with out_ready=1 -> IDLE; out_valid is 0 in the next cycle.
REQ-022 Latency: job accepted at cycle T gives load_val at T+1, rounds at T+2..T+1+req_rounds, out_valid first at T+2+req_rounds.
REQ-023 In IDLE, round_ctr SHALL equal NUM_ROUNDS and load_val, rounds_enable, out_valid SHALL be 0.
REQ-024 req_valid asserted outside IDLE SHALL be ignored; the job is accepted only once the FSM returns to IDLE.
REQ-025 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-026 When rst=1 at a clock edge the FSM SHALL enter IDLE regardless of current state, including mid-ROUND.
REQ-027 Reset values: round_ctr=NUM_ROUNDS, load_val=0, rounds_enable=0, out_valid=0, busy=0, err=0; req_ready=1 in the cycle after reset.
REQ-028 A job presented in the same cycle as rst=1 SHALL NOT be accepted.

Configuration
REQ-029 Macro ASCON_PERM_CTRL_ROUND_CHECK_EN SHALL select illegal round-count handling; illegal means req_rounds==0 or req_rounds>NUM_ROUNDS.
REQ-030 With the macro defined: an illegal job completes the handshake, FSM stays in IDLE, err=1 for exactly the following cycle, no load_val issued.
REQ-031 Without the macro: an illegal req_rounds SHALL be treated as NUM_ROUNDS, and err is constant 0.

Verification
REQ-032 rst then req_valid=1, req_rounds=12 at cycle 0 -> load_val at cycle 1 (round_ctr=0), rounds_enable cycles 2..13 with round_ctr 0..11, out_valid from cycle 14 with round_ctr=12.
REQ-033 req_rounds=6 accepted at cycle 0, out_ready=1 -> round_ctr 6..11 on cycles 2..7, out_valid only on cycle 8, IDLE and req_ready=1 on cycle 9.
REQ-034 req_rounds=8, out_ready=0 for 5 cycles after out_valid rises -> out_valid, round_ctr=12 held 5 cycles; second req_valid during this time not accepted until after return to IDLE.
REQ-035 rst=1 on third ROUND cycle of a 12-round job -> next cycle IDLE, rounds_enable=0, round_ctr=12, busy=0, no out_valid.
REQ-036 req_rounds=0 and req_rounds=13: with ASCON_PERM_CTRL_ROUND_CHECK_EN -> err pulse one cycle, no load_val; without -> full 12-round sequence, err=0.

Source files
------------

// File: rtl/ascon_perm_ctrl.sv
// Round-sequencing controller for an Ascon permutation datapath: accepts a job,
// strobes the state load, issues round indices, then holds the result until consumed.
// Optional macro ASCON_PERM_CTRL_ROUND_CHECK_EN rejects illegal round counts with an err pulse.
module ascon_perm_ctrl #(
    parameter int NUM_ROUNDS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_rounds,
    output logic       req_ready,
    output logic       load_val,
    output logic       rounds_enable,
    output logic [3:0] round_ctr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    localparam logic [3:0] NR       = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAST_IDX = NR - 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } state_t;

    state_t     state_q;
    logic [3:0] round_ctr_q;
    logic       load_val_q;
    logic       rounds_en_q;
    logic       out_valid_q;
    logic       busy_q;
    logic       rounds_illegal;
    logic [3:0] start_ctr_d;

    // A job of r rounds runs the final r round constants, so it starts at NR - r.
    always_comb begin
        rounds_illegal = (req_rounds == 4'd0) || (req_rounds > NR);
        start_ctr_d    = rounds_illegal ? 4'd0 : NR - req_rounds;
    end

`ifdef ASCON_PERM_CTRL_ROUND_CHECK_EN
    logic err_q;
`endif

    // NOTE: every register here uses <= so all of them sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            round_ctr_q <= NR;
            load_val_q  <= 1'b0;
            rounds_en_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ASCON_PERM_CTRL_ROUND_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef ASCON_PERM_CTRL_ROUND_CHECK_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
`ifdef ASCON_PERM_CTRL_ROUND_CHECK_EN
                        if (rounds_illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= LOAD;
                            round_ctr_q <= start_ctr_d;
                            load_val_q  <= 1'b1;
                            busy_q      <= 1'b1;
                        end
`else
                        state_q     <= LOAD;
                        round_ctr_q <= start_ctr_d;
                        load_val_q  <= 1'b1;
                        busy_q      <= 1'b1;
`endif
                    end
                end
                LOAD: begin
                    state_q     <= ROUND;
                    load_val_q  <= 1'b0;
                    rounds_en_q <= 1'b1;
                end
                ROUND: begin
                    if (round_ctr_q == LAST_IDX) begin
                        state_q     <= DONE;
                        round_ctr_q <= NR;
                        rounds_en_q <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_ctr_q <= round_ctr_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign load_val      = load_val_q;
    assign rounds_enable = rounds_en_q;
    assign round_ctr     = round_ctr_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
`ifdef ASCON_PERM_CTRL_ROUND_CHECK_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule
